// File: rtl/demux_sel_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// demux_sel_sequencer_pkg
// Shared definitions for the demux select sequencer and its benches.
//   NUM_CH   : number of demux channels (frame width in bits)
//   SEL_W    : width of the channel select, clog2(NUM_CH)
//   state_t  : sequencer FSM encoding (ST_IDLE = 1'b0, ST_SHIFT = 1'b1)
// ----------------------------------------------------------------------------
package demux_sel_sequencer_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/demux_sel_counter.sv
// ----------------------------------------------------------------------------
// demux_sel_counter
// SEL_W-bit up/down counter with load-to-start, enable and terminal count.
// Counting up it runs 0 .. NUM_CH-1; counting down it runs NUM_CH-1 .. 0.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset (count -> 0)
//   load  in   load the start value (has priority over en)
//   en    in   advance one step
//   cnt   out  current count
//   tc    out  count is at its terminal value for the current direction
// ----------------------------------------------------------------------------
module demux_sel_counter #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3,
  parameter bit DOWN   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);

  localparam logic [SEL_W-1:0] LAST      = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] START_VAL = DOWN ? LAST : '0;
  localparam logic [SEL_W-1:0] END_VAL   = DOWN ? '0 : LAST;

  logic [SEL_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= START_VAL;
    end else if (en) begin
      cnt_reg <= DOWN ? (cnt_reg - 1'b1) : (cnt_reg + 1'b1);
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == END_VAL);

endmodule

// File: rtl/demux_sel_sequencer.sv
// ----------------------------------------------------------------------------
// demux_sel_sequencer
// Accepts an NUM_CH-bit frame over valid/ready and serialises it one bit per
// clock onto demux_in, with sel naming the destination demux channel.
// Build option: define DEMUX_SEQ_MSB_FIRST_EN to emit the frame MSB first
// (sel counts NUM_CH-1 down to 0); otherwise LSB first (sel 0 up).
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   frame offered on in_data
//   in_data     in   frame; bit k goes to channel k
//   in_ready    out  frame can be accepted this cycle
//   out_en      in   downstream enable; low stalls and holds outputs
//   sel         out  channel select to demux
//   demux_in    out  serial data bit to demux
//   out_valid   out  sel/demux_in carry a live bit
//   frame_done  out  one-cycle pulse with the last bit of a frame
// ----------------------------------------------------------------------------
module demux_sel_sequencer
  import demux_sel_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NUM_CH-1:0] in_data,
  output logic              in_ready,
  input  logic              out_en,
  output logic [SEL_W-1:0]  sel,
  output logic              demux_in,
  output logic              out_valid,
  output logic              frame_done
);

`ifdef DEMUX_SEQ_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_t            state_reg;
  state_t            state_next;
  logic [NUM_CH-1:0] frame_reg;
  logic [SEL_W-1:0]  cnt;
  logic              cnt_tc;
  logic              accept;
  logic              cnt_load;
  logic              cnt_en;

  // Counter is reloaded both on accept and at end of frame, so it always
  // sits at the start value when a fresh frame begins.
  demux_sel_counter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W),
    .DOWN   (MSB_FIRST)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .cnt  (cnt),
    .tc   (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg <= '0;
    end else if (accept) begin
      frame_reg <= in_data;
    end
  end

  // Outputs are decoded from registered state only (plus out_en/in_valid for
  // the handshake), so an asynchronous reset clears them without a clock.
  always_comb begin
    state_next = state_reg;
    out_valid  = 1'b0;
    sel        = '0;
    demux_in   = 1'b0;
    frame_done = 1'b0;
    in_ready   = 1'b0;
    accept     = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        cnt_load = in_valid;
        if (in_valid) begin
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        out_valid  = 1'b1;
        sel        = cnt;
        demux_in   = frame_reg[cnt];
        cnt_en     = out_en;
        frame_done = out_en && cnt_tc;
        // Last bit frees the slot this same cycle: no bubble between frames.
        in_ready   = frame_done;
        accept     = frame_done && in_valid;
        cnt_load   = frame_done;
        if (frame_done && !in_valid) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
